// File: rtl/top_if.sv
// Configuration bus interface for the pad ALU block.
// The write side (master) drives an address and data word; address 0 means
// "no write this cycle". The register file (slave) samples both on clk_in.
interface top_cfg_if;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (output addr, output data);
    modport slave  (input  addr, input  data);
endinterface

// File: rtl/top.sv
// Pad ALU block: three 16-bit input pad words feed a small configurable ALU
// whose result drives one 16-bit output pad word.
// A 32-bit configuration bus selects operands, constant, opcode and enable.
// Optional macro TOP_OUTPUT_REG_EN inserts one output register (one-cycle
// latency); without it the output is purely combinational from the pads.
// JTAG pins are accepted but have no function; tdo is tied low.

module top_core (
    input  logic         clk_in,
    input  logic         reset_in,
    top_cfg_if.slave     cfg,
    input  logic [15:0]  s0_i,
    input  logic [15:0]  s1_i,
    input  logic [15:0]  s2_i,
    output logic [15:0]  word_o
);
    logic [1:0]  asel_q,   asel_d;
    logic [1:0]  bsel_q,   bsel_d;
    logic [15:0] const_q,  const_d;
    logic [3:0]  opcode_q, opcode_d;
    logic        outen_q,  outen_d;

    logic [15:0] opA;
    logic [15:0] opB;
    logic [15:0] result;
    logic [15:0] gated;

    // Only the low bits of each data word are meaningful to the registers.
    logic unused_cfgData;
    assign unused_cfgData = ^cfg.data[31:16];

    // Next-state for the register file: a nonzero address loads one register,
    // unknown addresses leave everything untouched.
    always_comb begin
        asel_d   = asel_q;
        bsel_d   = bsel_q;
        const_d  = const_q;
        opcode_d = opcode_q;
        outen_d  = outen_q;
        case (cfg.addr)
            32'h1:   asel_d   = cfg.data[1:0];
            32'h2:   bsel_d   = cfg.data[1:0];
            32'h3:   const_d  = cfg.data[15:0];
            32'h4:   opcode_d = cfg.data[3:0];
            32'h5:   outen_d  = cfg.data[0];
            default: ;
        endcase
    end

    // Register file; reset wins over any concurrent configuration write.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            asel_q   <= 2'd0;
            bsel_q   <= 2'd0;
            const_q  <= 16'h0000;
            opcode_q <= 4'd0;
            outen_q  <= 1'b0;
        end else begin
            asel_q   <= asel_d;
            bsel_q   <= bsel_d;
            const_q  <= const_d;
            opcode_q <= opcode_d;
            outen_q  <= outen_d;
        end
    end

    // Operand selection: each operand picks one pad word or the constant.
    always_comb begin
        opA = 16'h0000;
        opB = 16'h0000;
        case (asel_q)
            2'd0:    opA = s0_i;
            2'd1:    opA = s1_i;
            2'd2:    opA = s2_i;
            default: opA = const_q;
        endcase
        case (bsel_q)
            2'd0:    opB = s0_i;
            2'd1:    opB = s1_i;
            2'd2:    opB = s2_i;
            default: opB = const_q;
        endcase
    end

    // ALU: all arithmetic wraps to 16 bits, shifts use only the low nibble of B.
    always_comb begin
        result = 16'h0000;
        case (opcode_q)
            4'd0:    result = opA;
            4'd1:    result = opA + opB;
            4'd2:    result = opA - opB;
            4'd3:    result = opA * opB;
            4'd4:    result = opA << opB[3:0];
            4'd5:    result = opA >> opB[3:0];
            4'd6:    result = opA & opB;
            4'd7:    result = opA | opB;
            4'd8:    result = opA ^ opB;
            default: result = 16'h0000;
        endcase
    end

    // Output enable gates the ALU result to zero when the block is disabled.
    always_comb begin
        gated = outen_q ? result : 16'h0000;
    end

`ifdef TOP_OUTPUT_REG_EN
    logic [15:0] word_q;

    // Optional output stage: one cycle of latency, cleared by reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            word_q <= 16'h0000;
        end else begin
            word_q <= gated;
        end
    end

    assign word_o = word_q;
`else
    assign word_o = gated;
`endif
endmodule

module top (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [31:0] config_addr_in,
    input  logic [31:0] config_data_in,
    input  logic pad_S0_T0_in,  input  logic pad_S0_T1_in,  input  logic pad_S0_T2_in,  input  logic pad_S0_T3_in,
    input  logic pad_S0_T4_in,  input  logic pad_S0_T5_in,  input  logic pad_S0_T6_in,  input  logic pad_S0_T7_in,
    input  logic pad_S0_T8_in,  input  logic pad_S0_T9_in,  input  logic pad_S0_T10_in, input  logic pad_S0_T11_in,
    input  logic pad_S0_T12_in, input  logic pad_S0_T13_in, input  logic pad_S0_T14_in, input  logic pad_S0_T15_in,
    input  logic pad_S1_T0_in,  input  logic pad_S1_T1_in,  input  logic pad_S1_T2_in,  input  logic pad_S1_T3_in,
    input  logic pad_S1_T4_in,  input  logic pad_S1_T5_in,  input  logic pad_S1_T6_in,  input  logic pad_S1_T7_in,
    input  logic pad_S1_T8_in,  input  logic pad_S1_T9_in,  input  logic pad_S1_T10_in, input  logic pad_S1_T11_in,
    input  logic pad_S1_T12_in, input  logic pad_S1_T13_in, input  logic pad_S1_T14_in, input  logic pad_S1_T15_in,
    input  logic pad_S2_T0_in,  input  logic pad_S2_T1_in,  input  logic pad_S2_T2_in,  input  logic pad_S2_T3_in,
    input  logic pad_S2_T4_in,  input  logic pad_S2_T5_in,  input  logic pad_S2_T6_in,  input  logic pad_S2_T7_in,
    input  logic pad_S2_T8_in,  input  logic pad_S2_T9_in,  input  logic pad_S2_T10_in, input  logic pad_S2_T11_in,
    input  logic pad_S2_T12_in, input  logic pad_S2_T13_in, input  logic pad_S2_T14_in, input  logic pad_S2_T15_in,
    output logic pad_S0_T0_out,  output logic pad_S0_T1_out,  output logic pad_S0_T2_out,  output logic pad_S0_T3_out,
    output logic pad_S0_T4_out,  output logic pad_S0_T5_out,  output logic pad_S0_T6_out,  output logic pad_S0_T7_out,
    output logic pad_S0_T8_out,  output logic pad_S0_T9_out,  output logic pad_S0_T10_out, output logic pad_S0_T11_out,
    output logic pad_S0_T12_out, output logic pad_S0_T13_out, output logic pad_S0_T14_out, output logic pad_S0_T15_out,
    input  logic tdi,
    input  logic tms,
    input  logic tck,
    input  logic trst_n,
    output logic tdo
);
    logic [15:0] s0Word;
    logic [15:0] s1Word;
    logic [15:0] s2Word;
    logic [15:0] outWord;

    top_cfg_if cfgBus ();

    // JTAG has no function in this block.
    logic unused_jtag;
    assign unused_jtag = ^{tdi, tms, tck, trst_n};
    assign tdo = 1'b0;

    assign cfgBus.addr = config_addr_in;
    assign cfgBus.data = config_data_in;

    // Pad T0 is the word MSB on every side.
    assign s0Word = {pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,
                     pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
                     pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in,
                     pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
    assign s1Word = {pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,
                     pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
                     pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in,
                     pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
    assign s2Word = {pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,
                     pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
                     pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in,
                     pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};

    assign {pad_S0_T0_out,  pad_S0_T1_out,  pad_S0_T2_out,  pad_S0_T3_out,
            pad_S0_T4_out,  pad_S0_T5_out,  pad_S0_T6_out,  pad_S0_T7_out,
            pad_S0_T8_out,  pad_S0_T9_out,  pad_S0_T10_out, pad_S0_T11_out,
            pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = outWord;

    top_core u_core (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .cfg      (cfgBus.slave),
        .s0_i     (s0Word),
        .s1_i     (s1Word),
        .s2_i     (s2Word),
        .word_o   (outWord)
    );
endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the pad ALU block.
// Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
// Expectations follow TOP_OUTPUT_REG_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_top;
    logic        clk;
    logic        reset;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] s2;
    logic        tdi, tms, tck, trstN;
    logic        tdo;
    logic [15:0] outWord;
    logic [15:0] prevS2;
    int          checkCount;
    int          errorCount;

    top_cfg_if cfgBus ();

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    top dut (
        .clk_in(clk), .reset_in(reset),
        .config_addr_in(cfgBus.addr), .config_data_in(cfgBus.data),
        .pad_S0_T0_in(s0[15]),  .pad_S0_T1_in(s0[14]),  .pad_S0_T2_in(s0[13]),  .pad_S0_T3_in(s0[12]),
        .pad_S0_T4_in(s0[11]),  .pad_S0_T5_in(s0[10]),  .pad_S0_T6_in(s0[9]),   .pad_S0_T7_in(s0[8]),
        .pad_S0_T8_in(s0[7]),   .pad_S0_T9_in(s0[6]),   .pad_S0_T10_in(s0[5]),  .pad_S0_T11_in(s0[4]),
        .pad_S0_T12_in(s0[3]),  .pad_S0_T13_in(s0[2]),  .pad_S0_T14_in(s0[1]),  .pad_S0_T15_in(s0[0]),
        .pad_S1_T0_in(s1[15]),  .pad_S1_T1_in(s1[14]),  .pad_S1_T2_in(s1[13]),  .pad_S1_T3_in(s1[12]),
        .pad_S1_T4_in(s1[11]),  .pad_S1_T5_in(s1[10]),  .pad_S1_T6_in(s1[9]),   .pad_S1_T7_in(s1[8]),
        .pad_S1_T8_in(s1[7]),   .pad_S1_T9_in(s1[6]),   .pad_S1_T10_in(s1[5]),  .pad_S1_T11_in(s1[4]),
        .pad_S1_T12_in(s1[3]),  .pad_S1_T13_in(s1[2]),  .pad_S1_T14_in(s1[1]),  .pad_S1_T15_in(s1[0]),
        .pad_S2_T0_in(s2[15]),  .pad_S2_T1_in(s2[14]),  .pad_S2_T2_in(s2[13]),  .pad_S2_T3_in(s2[12]),
        .pad_S2_T4_in(s2[11]),  .pad_S2_T5_in(s2[10]),  .pad_S2_T6_in(s2[9]),   .pad_S2_T7_in(s2[8]),
        .pad_S2_T8_in(s2[7]),   .pad_S2_T9_in(s2[6]),   .pad_S2_T10_in(s2[5]),  .pad_S2_T11_in(s2[4]),
        .pad_S2_T12_in(s2[3]),  .pad_S2_T13_in(s2[2]),  .pad_S2_T14_in(s2[1]),  .pad_S2_T15_in(s2[0]),
        .pad_S0_T0_out(outWord[15]), .pad_S0_T1_out(outWord[14]), .pad_S0_T2_out(outWord[13]), .pad_S0_T3_out(outWord[12]),
        .pad_S0_T4_out(outWord[11]), .pad_S0_T5_out(outWord[10]), .pad_S0_T6_out(outWord[9]),  .pad_S0_T7_out(outWord[8]),
        .pad_S0_T8_out(outWord[7]),  .pad_S0_T9_out(outWord[6]),  .pad_S0_T10_out(outWord[5]), .pad_S0_T11_out(outWord[4]),
        .pad_S0_T12_out(outWord[3]), .pad_S0_T13_out(outWord[2]), .pad_S0_T14_out(outWord[1]), .pad_S0_T15_out(outWord[0]),
        .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trstN), .tdo(tdo)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // One configuration write lasting exactly one rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cfgBus.addr = addr;
        cfgBus.data = data;
        @(posedge clk);
        #1;
        cfgBus.addr = 32'h0;
        cfgBus.data = 32'h0;
    endtask

    // Let a static pad/config pattern propagate in either output mode, then sample.
    task automatic settleAndCheck(input string tag, input logic [15:0] expected);
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag, outWord, expected);
    endtask

    // Operand A = S0, operand B = S1, output enabled, then sweep opcodes.
    task automatic checkOpcode(input logic [3:0] op, input logic [15:0] expected, input string tag);
        applyStimulus(32'h4, {28'h0, op});
        settleAndCheck(tag, expected);
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        cfgBus.addr  = 32'h0;
        cfgBus.data  = 32'h0;
        s0 = 16'h0; s1 = 16'h0; s2 = 16'h0;
        tdi = 1'b0; tms = 1'b0; tck = 1'b0; trstN = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Post-reset output is zero with the bus idle and S2 driven.
        s2 = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d", i), outWord, 16'h0000);
        end
        checkOutput("tdoReset", {15'h0, tdo}, 16'h0000);

        // A=S2, B=CONST=2, multiply; the enable write shows the edge latency.
        applyStimulus(32'h1, 32'h2);
        applyStimulus(32'h2, 32'h3);
        applyStimulus(32'h3, 32'h2);
        applyStimulus(32'h4, 32'h3);
        @(negedge clk);
        checkOutput("beforeEnable", outWord, 16'h0000);
        applyStimulus(32'h5, 32'h1);
        @(negedge clk);
`ifdef TOP_OUTPUT_REG_EN
        checkOutput("enableLatency", outWord, 16'h0000);
`else
        checkOutput("enableLatency", outWord, 16'h2468);
`endif

        // Count S2 once per cycle; output is 2*S2 (or 2*previous S2 when registered).
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            prevS2 = s2;
            #1 s2 = 16'(i);
            @(negedge clk);
`ifdef TOP_OUTPUT_REG_EN
            checkOutput($sformatf("count%0d", i), outWord, 16'(prevS2 * 2));
`else
            checkOutput($sformatf("count%0d", i), outWord, 16'(i * 2));
`endif
            checkOutput("tdoCount", {15'h0, tdo}, 16'h0000);
        end

        // Full opcode sweep with A=0x1234 and B=0x0005.
        applyStimulus(32'h1, 32'h0);
        applyStimulus(32'h2, 32'h1);
        s0 = 16'h1234; s1 = 16'h0005;
        checkOpcode(4'd0,  16'h1234, "opPass");
        checkOpcode(4'd1,  16'h1239, "opAdd");
        checkOpcode(4'd2,  16'h122F, "opSub");
        checkOpcode(4'd3,  16'h5B04, "opMul");
        checkOpcode(4'd4,  16'h4680, "opShl");
        checkOpcode(4'd5,  16'h0091, "opShr");
        checkOpcode(4'd6,  16'h0004, "opAnd");
        checkOpcode(4'd7,  16'h1235, "opOr");
        checkOpcode(4'd8,  16'h1231, "opXor");
        checkOpcode(4'd9,  16'h0000, "op9");
        checkOpcode(4'd15, 16'h0000, "op15");

        // Wrap on overflow and underflow.
        s0 = 16'hFFFF; s1 = 16'h0002;
        checkOpcode(4'd1, 16'h0001, "addWrap");
        s0 = 16'h0000; s1 = 16'h0001;
        checkOpcode(4'd2, 16'hFFFF, "subWrap");

        // Shift amount uses only B[3:0]: CONST=0x13 shifts by 3.
        applyStimulus(32'h4, 32'h4);
        applyStimulus(32'h1, 32'h2);
        applyStimulus(32'h2, 32'h3);
        applyStimulus(32'h3, 32'h13);
        s2 = 16'h0001;
        settleAndCheck("shiftNibble", 16'h0008);

        // Reconfigure as multiply-by-2, then reset with a concurrent enable write.
        applyStimulus(32'h3, 32'h2);
        applyStimulus(32'h4, 32'h3);
        s2 = 16'h0005;
        settleAndCheck("preReset", 16'h000A);
        @(negedge clk);
        reset = 1'b1;
        cfgBus.addr = 32'h5;
        cfgBus.data = 32'h1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cfgBus.addr = 32'h0;
        cfgBus.data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("postReset%0d", i), outWord, 16'h0000);
        end
        applyStimulus(32'h7, 32'hFFFF_FFFF);
        settleAndCheck("unknownAddr", 16'h0000);

        // Enabling after reset exposes cleared selects/opcode: R = S0.
        s0 = 16'hBEEF;
        applyStimulus(32'h5, 32'h1);
        settleAndCheck("clearedRegs", 16'hBEEF);

        // Upper data bits ignored: 0xFFFFFFF1 selects opcode 1, S0+S0.
        applyStimulus(32'h4, 32'hFFFF_FFF1);
        settleAndCheck("upperBits", 16'h7DDE);

        // Back-to-back writes to one address: the second wins (AND of S0,S0).
        applyStimulus(32'h4, 32'h8);
        applyStimulus(32'h4, 32'h6);
        settleAndCheck("lastWrite", 16'hBEEF);

        checkOutput("tdoEnd", {15'h0, tdo}, 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-high, and ports are named clk_in and reset_in.
REQ-002 Port clk_in, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset_in, input, 1 bit: synchronous, active-high reset.
REQ-004 Port config_addr_in, input, 32 bits: configuration register address; 0 means no write.
REQ-005 Port config_data_in, input, 32 bits: configuration write data.
REQ-006 Ports pad_S0_T0_in..pad_S0_T15_in, input, 1 bit each: side-0 input pad word.
REQ-007 Ports pad_S1_T0_in..pad_S1_T15_in, input, 1 bit each: side-1 input pad word.
REQ-008 Ports pad_S2_T0_in..pad_S2_T15_in, input, 1 bit each: side-2 input pad word.
REQ-009 Ports pad_S0_T0_out..pad_S0_T15_out, output, 1 bit each: side-0 output pad word.
REQ-010 Ports tdi, tms, tck, trst_n, input, 1 bit each: JTAG pins, functionally ignored.
REQ-011 Port tdo, output, 1 bit: SHALL be driven constant 0.
REQ-012 Each pad word SHALL be assembled as {T0..T15}, with pad Tk mapped to word bit 15-k (T0 is the MSB) on both input and output.

Function
REQ-013 Register writes: on a rising edge with reset_in=0 and config_addr_in!=0, the register at config_addr_in SHALL load from config_data_in; unknown addresses SHALL be ignored.
REQ-014 Register map:
  - 0x1 ASEL[1:0]: operand A source (0=S0, 1=S1, 2=S2, 3=CONST).
  - 0x2 BSEL[1:0]: operand B source, same encoding.
  - 0x3 CONST[15:0].
  - 0x4 OPCODE[3:0].
  - 0x5 OUT_EN[0].
  - Unused data bits ignored.
REQ-015 Opcode result R (16 bits, modulo 2^16), evaluated combinationally on operands A and B:
  - 0: A
  - 1: A+B
  - 2: A-B
  - 3: low 16 bits of A*B
  - 4: A<<B[3:0]
  - 5: A>>B[3:0] (logical)
  - 6: A&B
  - 7: A|B
  - 8: A^B
  - 9–15: 0
REQ-016 Output word SHALL equal R when OUT_EN=1, else 16'h0000.
REQ-017 Without the macro, the output SHALL be purely combinational from the pads: zero-cycle latency, updating in the same cycle the pads change.
REQ-018 A configuration write SHALL affect the output from the cycle after the writing edge.
REQ-019 Consecutive writes to the same address SHALL be last-write-wins, one write per cycle.
REQ-020 Overflow, underflow and shift amounts 0..15 SHALL wrap or truncate to 16 bits with no flags.

Reset
REQ-021 While reset_in=1 at a rising edge, ASEL, BSEL, CONST, OPCODE and OUT_EN SHALL clear to 0; any concurrent configuration write is discarded.
REQ-022 After reset the output word SHALL be 16'h0000, because OUT_EN=0.
REQ-023 Reset asserted mid-operation SHALL return the block to the post-reset state on that edge; no other state exists.

Configuration
REQ-024 Macro TOP_OUTPUT_REG_EN, when defined, SHALL insert one output register clocked by clk_in.
  - The register is reset synchronously to 0.
  - Output latency becomes exactly one cycle after pad or configuration change.
REQ-025 When TOP_OUTPUT_REG_EN is undefined, the output path SHALL have no register (per REQ-017).

Verification
REQ-026 Reset, then hold config_addr_in=0 for 5 cycles with S2 pads = 0x1234 -> output 0x0000 every cycle.
REQ-027 Write ASEL=2, BSEL=3, CONST=2, OPCODE=3, OUT_EN=1, then count the S2 word 0,1,2,... once per cycle -> output = 2 x S2 in the same cycle (macro off).
REQ-028 Write OPCODE=1, ASEL=0, BSEL=1; S0=0xFFFF, S1=0x0002 -> output 0x0001 (wrap).
REQ-029 Write OPCODE=4, ASEL=2, BSEL=3, CONST=0x13; S2=0x0001 -> output 0x0008 (shift uses B[3:0]=3).
REQ-030 Configure per REQ-027, then assert reset_in for one cycle -> output 0x0000 on the next cycle and thereafter until reconfigured; write to address 0x7 -> no change.
REQ-031 With TOP_OUTPUT_REG_EN defined, run REQ-027 stimulus -> output equals 2 x the previous cycle's S2 word; tdo = 0 throughout.
